// File: rtl/programmable_freq_generator.sv
`default_nettype none
// ============================================================================
// Module      : programmable_freq_generator
// Description : Runtime-programmable square-wave generator with decimal
//               readout. A binary frequency request is clamped, converted to
//               a half-period cycle count by a 32-step restoring divider and
//               to BCD by a sequential double-dabble, then drives LED and a
//               multiplexed seven-segment display.
// Ports       : clock              - system clock, rising edge
//               reset              - asynchronous active-high reset
//               freq_sel[FREQ_W]   - requested frequency in Hz, binary
//               load               - strobe: sample freq_sel and recompute
//               LED                - generated square wave
//               tick               - 1-cycle pulse on every LED toggle
//               busy               - recompute in progress
//               freq_now[FREQ_W]   - frequency currently generated (clamped)
//               seg[7]             - {g,f,e,d,c,b,a}, active-low
//               SevenSegmentEnable[DIGITS] - active-low one-hot digit enable
//               dot                - decimal point, held off (1)
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_freq_generator #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int          FREQ_W   = 10,
    parameter int          MAX_FREQ = 999,
    parameter int          DIGITS   = 3,
    parameter int unsigned SCAN_HZ  = 500,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FREQ_W-1:0] freq_sel,
    input  logic              load,
    output logic              LED,
    output logic              tick,
    output logic              busy,
    output logic [FREQ_W-1:0] freq_now,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] SevenSegmentEnable,
    output logic              dot
);

    localparam int          BCD_W    = DIGITS * 4;
    localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_BCD, S_COMMIT} state_t;

    state_t            state_q, state_d;
    logic              busy_q;
    logic              pending_q, pending_d;
    logic [FREQ_W-1:0] f_q, f_d;
    logic [31:0]       quo_q, quo_d;      // dividend shifts out as quotient shifts in
    logic [31:0]       rem_q, rem_d;
    logic [5:0]        seq_q, seq_d;
    logic [FREQ_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [31:0]       half_q, half_d;
    logic [FREQ_W-1:0] freq_now_q, freq_now_d;
    logic [BCD_W-1:0]  disp_q, disp_d;

    logic [FREQ_W-1:0] w_clamped;
    logic [32:0]       w_rem_sh;
    logic [32:0]       w_divisor;
    logic [31:0]       w_rem_sub;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic              w_start;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    always_comb begin
        w_clamped = (freq_sel > FREQ_W'(MAX_FREQ)) ? FREQ_W'(MAX_FREQ) : freq_sel;
        w_rem_sh  = {rem_q, quo_q[31]};
        w_divisor = 33'({f_q, 1'b0});
        w_rem_sub = 32'(w_rem_sh - w_divisor);
        // Double-dabble: bias every digit >= 5 before the shift.
        w_bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Recompute FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        f_d        = f_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        seq_d      = seq_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        half_d     = half_q;
        freq_now_d = freq_now_q;
        disp_d     = disp_q;
        w_start    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load) w_start = 1'b1;
            end
            S_DIVIDE: begin
                if (load) pending_d = 1'b1;
                seq_d = seq_q + 6'd1;
                if (w_rem_sh >= w_divisor) begin
                    rem_d = w_rem_sub;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = w_rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (seq_q == 6'd31) begin
                    state_d = S_BCD;
                    seq_d   = '0;
                    bin_d   = f_q;
                    bcd_d   = '0;
                end
            end
            S_BCD: begin
                if (load) pending_d = 1'b1;
                seq_d = seq_q + 6'd1;
                bcd_d = BCD_W'({w_bcd_adj, bin_q[FREQ_W-1]});
                bin_d = bin_q << 1;
                if (seq_q == 6'(FREQ_W - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // f=0 ignores the meaningless divide-by-zero quotient.
                if (f_q == '0)        half_d = '0;
                else if (quo_q == '0) half_d = 32'd1;
                else                  half_d = quo_q;
                freq_now_d = f_q;
                disp_d     = bcd_q;
                pending_d  = 1'b0;
                // A load seen during this recompute (or right now) reruns at once.
                if (pending_q || load) w_start = 1'b1;
                else                   state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_start) begin
            state_d = S_DIVIDE;
            f_d     = w_clamped;
            quo_d   = CLK_HZ;
            rem_d   = '0;
            seq_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            f_q        <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            seq_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            half_q     <= '0;
            freq_now_q <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != S_IDLE);
            pending_q  <= pending_d;
            f_q        <= f_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            seq_q      <= seq_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            half_q     <= half_d;
            freq_now_q <= freq_now_d;
            disp_q     <= disp_d;
        end
    end

    // ------------------------------------------------------------------
    // Square-wave generator; counter is not cleared on a new half_q, so a
    // shorter limit already exceeded toggles on the next cycle.
    // ------------------------------------------------------------------
    logic [31:0] gcnt_q;
    logic        led_q;
    logic        tick_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gcnt_q <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (half_q == '0) begin
            gcnt_q <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (gcnt_q >= half_q - 32'd1) begin
            gcnt_q <= '0;
            led_q  <= ~led_q;
            tick_q <= 1'b1;
        end else begin
            gcnt_q <= gcnt_q + 32'd1;
            tick_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [31:0]       pre_q;
    logic [IDX_W-1:0]  idx_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] en_q;
    logic [3:0]        w_digit;
    logic              w_blank;
    logic [6:0]        w_seg;

    always_comb begin
        w_digit = disp_q[{idx_q, 2'b00} +: 4];
        // Leading zero: this digit and everything above it are zero.
        w_blank = BLANK_LZ && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
        w_seg   = 7'h7F;
        if (!w_blank) begin
            unique case (w_digit)
                4'd0:    w_seg = 7'h40;
                4'd1:    w_seg = 7'h79;
                4'd2:    w_seg = 7'h24;
                4'd3:    w_seg = 7'h30;
                4'd4:    w_seg = 7'h19;
                4'd5:    w_seg = 7'h12;
                4'd6:    w_seg = 7'h02;
                4'd7:    w_seg = 7'h78;
                4'd8:    w_seg = 7'h00;
                4'd9:    w_seg = 7'h10;
                default: w_seg = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= 7'h7F;
            en_q  <= '1;
        end else begin
            if (pre_q == SCAN_DIV - 32'd1) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 32'd1;
            end
            en_q  <= ~(DIGITS'(1) << idx_q);
            seg_q <= w_seg;
        end
    end

    assign LED                = led_q;
    assign tick               = tick_q;
    assign busy               = busy_q;
    assign freq_now           = freq_now_q;
    assign seg                = seg_q;
    assign SevenSegmentEnable = en_q;
    assign dot                = 1'b1;

endmodule
`default_nettype wire
